// File: rtl/burst_ag_pkg.sv
// Shared types and default widths for the strided burst address generator.
package burst_ag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } burst_ag_state_t;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned LW_DEF = 16;
  localparam int unsigned SW_DEF = 8;
  localparam int unsigned CW_DEF = 16;

endpackage

// File: rtl/burst_addr_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority over increment; increment stops at the maximum value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/burst_addr_gen.sv
// Strided burst address generator: one address per valid/ready handshake,
// final address flagged with last_o, one-cycle done_o at completion.
// Optional stall counter port is compiled in with BURST_AG_STALL_CNT_EN.
module burst_addr_gen
  import burst_ag_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF,
  parameter int unsigned SW = SW_DEF
`ifdef BURST_AG_STALL_CNT_EN
  ,parameter int unsigned CW = CW_DEF
`endif
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] len_i,
  input  logic [SW-1:0] stride_i,
  input  logic          abort_i,
  output logic          addr_valid_o,
  input  logic          addr_ready_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
`ifdef BURST_AG_STALL_CNT_EN
  ,output logic [CW-1:0] stall_cnt_o
`endif
);

  burst_ag_state_t state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_d;
  logic [LW-1:0]   cnt_q;
  logic [LW-1:0]   cnt_d;
  logic [LW-1:0]   len_q;
  logic [SW-1:0]   stride_q;
  logic            valid_q;
  logic            last_q;
  logic            busy_q;
  logic            done_q;
  logic            hs;

  // A handshake is only meaningful while an address is being offered.
  assign hs     = valid_q & addr_ready_i;
  // Stride is unsigned; the address wraps silently modulo 2^AW.
  assign addr_d = addr_q + {{(AW-SW){1'b0}}, stride_q};
  assign cnt_d  = cnt_q + 1'b1;

  // Control FSM with all outputs registered, so addr_ready_i never reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      stride_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            len_q    <= len_i;
            stride_q <= stride_i;
            addr_q   <= base_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (len_i != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              last_q  <= (len_i == LW'(1));
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
          end
          if (abort_i) begin
            // Abort wins over a coincident handshake and skips the done pulse.
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (hs && last_q) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (hs) begin
            last_q <= (cnt_d == (len_q - 1'b1));
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_valid_o = valid_q;
  assign addr_o       = addr_q;
  assign last_o       = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef BURST_AG_STALL_CNT_EN
  sat_counter #(
    .WIDTH (CW)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  ((state_q == IDLE) && start_i),
    .inc_i  (valid_q & ~addr_ready_i),
    .cnt_o  (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Self-checking bench for burst_addr_gen: directed bursts followed by
// randomized bursts, compared against an arithmetic model of the sequence.
module tb_burst_addr_gen;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] base_i;
  logic [15:0] len_i;
  logic [7:0]  stride_i;
  logic        abort_i;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic [31:0] addr_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
`ifdef BURST_AG_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  burst_addr_gen dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_i       (base_i),
    .len_i        (len_i),
    .stride_i     (stride_i),
    .abort_i      (abort_i),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .addr_o       (addr_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef BURST_AG_STALL_CNT_EN
    ,.stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input int exp_stall);
`ifdef BURST_AG_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, exp_stall);
`endif
  endtask

  // mode 0: ready always high; mode 1: random ready; mode 2: ready low for
  // two cycles while the second address is offered.
  // abort_k >= 0 asserts abort together with the handshake of element abort_k.
  // noisy drives random start/operand values during the burst.
  task automatic burst(input logic [31:0] b, input logic [15:0] l, input logic [7:0] s,
                       input int mode, input int abort_k, input bit noisy);
    int k, cyc, st_left, exp_stall;
    bit rdy, ab;
    logic [31:0] ea;
    k = 0; cyc = 0; st_left = 2; exp_stall = 0;
    chk("pre_busy", busy_o, 0);
    chk("pre_valid", addr_valid_o, 0);
    start_i = 1'b1; base_i = b; len_i = l; stride_i = s;
    @(negedge clk);
    start_i = 1'b0;
    if (l == 16'd0) begin
      chk("zl_done", done_o, 1);
      chk("zl_valid", addr_valid_o, 0);
      chk("zl_busy", busy_o, 1);
      chk_stall(0);
      @(negedge clk);
      chk("zl_done_end", done_o, 0);
      chk("zl_valid_end", addr_valid_o, 0);
      chk("zl_busy_end", busy_o, 0);
      return;
    end
    while (k < int'(l)) begin
      if (cyc > 2000) begin
        total++;
        fails++;
        $error("FAIL burst_timeout: observed %0d cycles, required at most 2000", cyc);
        break;
      end
      ea = b + 32'(k) * 32'(s);
      chk("run_valid", addr_valid_o, 1);
      chk("run_addr", addr_o, ea);
      chk("run_last", last_o, (k == int'(l) - 1));
      chk("run_done", done_o, 0);
      chk("run_busy", busy_o, 1);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(k == 1 && st_left > 0);
          if (!rdy) st_left--;
        end
      endcase
      addr_ready_i = rdy;
      ab = rdy && (k == abort_k);
      abort_i = ab;
      if (noisy) begin
        start_i  = 1'($urandom_range(0, 1));
        base_i   = $urandom;
        len_i    = 16'($urandom);
        stride_i = 8'($urandom);
      end
      if (!rdy) exp_stall++;
      @(negedge clk);
      cyc++;
      abort_i = 1'b0;
      start_i = 1'b0;
      if (ab) begin
        addr_ready_i = 1'b1;
        chk("ab_valid", addr_valid_o, 0);
        chk("ab_busy", busy_o, 0);
        chk("ab_done", done_o, 0);
        chk("ab_last", last_o, 0);
        chk_stall(exp_stall);
        @(negedge clk);
        chk("ab_done_after", done_o, 0);
        chk_stall(exp_stall);
        return;
      end
      if (rdy) k++;
    end
    addr_ready_i = 1'b1;
    chk("end_done", done_o, 1);
    chk("end_valid", addr_valid_o, 0);
    chk("end_busy", busy_o, 1);
    chk_stall(exp_stall);
    @(negedge clk);
    chk("idle_done", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", addr_valid_o, 0);
    chk_stall(exp_stall);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; stride_i = '0;
    abort_i = 1'b0; addr_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", addr_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk_stall(0);
    rst_ni = 1'b1;
    @(negedge clk);

    burst(32'h100, 16'd4, 8'd4, 0, -1, 1'b0);
    burst(32'h0, 16'd3, 8'd1, 2, -1, 1'b0);
    burst(32'h1234, 16'd0, 8'd7, 0, -1, 1'b0);
    burst(32'hFFFF_FFFC, 16'd3, 8'd4, 0, -1, 1'b0);
    burst(32'h2000, 16'd8, 8'd16, 0, 2, 1'b0);
    burst(32'h40, 16'd2, 8'd1, 0, -1, 1'b0);

    // abort while idle changes nothing
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("idle_abort_busy", busy_o, 0);
    chk("idle_abort_done", done_o, 0);
    chk("idle_abort_valid", addr_valid_o, 0);

    burst(32'h500, 16'd5, 8'd8, 1, -1, 1'b1);
    burst(32'h7, 16'd1, 8'd255, 1, -1, 1'b0);

    // asynchronous reset in the middle of a burst
    start_i = 1'b1; base_i = 32'h800; len_i = 16'd10; stride_i = 8'd2;
    @(negedge clk);
    start_i = 1'b0;
    addr_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_valid_pre", addr_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_valid", addr_valid_o, 0);
    chk("mr_addr", addr_o, 0);
    chk("mr_last", last_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_done", done_o, 0);
    chk_stall(0);
    @(negedge clk);
    rst_ni = 1'b1;
    addr_ready_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] rl;
      int          rk;
      rl = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      burst($urandom, rl, 8'($urandom), 1, rk, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/burst_addr_gen.md
# burst_addr_gen

Parametrised strided address generator for vector memory reads, the next generation of the free-running read counter. Given a base address, element count and stride, it emits one address per accepted valid/ready handshake, flags the final address, and pulses `done` when the burst completes. It sits between the vector load/store control and the data-memory read port.

## Interface

- `AW`, 32: address width in bits
- `LW`, 16: element-count width in bits
- `SW`, 8: stride width in bits, unsigned, zero-extended to `AW`
- `CW`, 16: stall-counter width; used only when the stall counter is compiled in

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  burst request; sampled only in IDLE
- `base`  in  AW  first address; sampled with `start`
- `len`  in  LW  number of addresses to emit; sampled with `start`
- `stride`  in  SW  address increment; sampled with `start`
- `abort`  in  1  cancel the current burst; effective only in RUN
- `addr_valid`  out  1  `addr` holds a valid address
- `addr_ready`  in  1  consumer accepts `addr` this cycle
- `addr`  out  AW  current address
- `last`  out  1  `addr` is the final address of the burst; qualified by `addr_valid`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse at burst completion
- `stall_cnt`  out  CW  cycles with `addr_valid & !addr_ready` (macro only)

## Operation

- Reset (`rst`=0, asynchronous): state IDLE; `addr`, count, `addr_valid`, `last`, `busy`, `done` and `stall_cnt` are all 0.
- States and transitions:
  - IDLE:
    - `start` & `len`≠0 -> RUN; latch `base`, `len`, `stride`; `addr`←`base`; count←0.
    - `start` & `len`=0 -> DONE; no address is emitted.
  - RUN: `addr_valid`=1.
    - A handshake (`addr_valid & addr_ready`) sets `addr`←`addr`+stride, mod 2^AW (silent wrap), and count←count+1.
    - `last`=1 while count = len−1.
    - A handshake while `last`=1 -> DONE.
  - DONE: `done`=1 and `addr_valid`=0 for one cycle, then IDLE.
- `addr` and `last` stay stable while `addr_valid & !addr_ready`.
- `start` is ignored outside IDLE. Latched `len`/`stride` are unaffected by later input changes.
- `abort` in RUN forces IDLE on the next edge with no `done` pulse.
  - `abort` in the same cycle as a handshake: the handshake counts as consumed, and abort still wins (IDLE).
- `abort` in IDLE or DONE has no effect.
- `addr_ready` is ignored when `addr_valid`=0.
- Maximum burst is 2^LW−1 addresses. The count uses LW bits and does not overflow.

## Timing

- `start` accepted at edge t: `addr_valid`=1 with `addr`=base from cycle t+1.
- With `addr_ready` held at 1: addresses appear at cycles t+1 … t+L, `done` at t+L+1, IDLE at t+L+2. The earliest next `start` is accepted at t+L+2.
- `len`=0: `done` at t+1, IDLE at t+2.
- Throughput is one address per cycle with no bubbles. Every output is registered, with no combinational path from `addr_ready` to any output.
- `busy` is high in RUN and DONE.

## Configuration

- Macro: `BURST_AG_STALL_CNT_EN`.
- Defined: the `stall_cnt` port exists.
  - Increments each cycle with `addr_valid & !addr_ready` and saturates at 2^CW−1.
  - Clears to 0 on an accepted `start`.
  - Holds its value after the burst completes or aborts.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure

- Package `burst_ag_pkg`:
  - state enum typedef `burst_ag_state_t` {IDLE, RUN, DONE}
  - default-width localparams
- Sub-module `sat_counter` (parameter width, inputs `clr`/`inc`, saturating) implements `stall_cnt`. It is instantiated only under the macro.
- The FSM, address register and element counter live in `burst_addr_gen`.

## Test plan

- Reset, then a burst with ready held at 1:
  - Check: all outputs are 0 after reset.
  - Stimulus: base=0x100, len=4, stride=4, `addr_ready`=1.
  - Required: `addr` = 0x100, 0x104, 0x108, 0x10C on consecutive cycles; `last` only with 0x10C; `done` one cycle later; `busy` falls one cycle after that.
- Backpressure:
  - Stimulus: base=0x0, len=3, stride=1; `addr_ready` low for 2 cycles on the second address.
  - Required: `addr`=0x1 is held stable for 3 cycles. With the macro defined, `stall_cnt`=2.
- Zero length and wrap:
  - `len`=0: `done` at t+1 and `addr_valid` is never asserted.
  - base=0xFFFF_FFFC, len=3, stride=4: addresses 0xFFFF_FFFC, 0x0, 0x4.
- Abort:
  - Stimulus: len=8; `abort` asserted together with the handshake of the third address.
  - Required: IDLE next cycle, no `done` pulse, `addr_valid`=0. A new `start` is then accepted normally.
- Ignored `start` and mid-burst reset:
  - `start` with new operands during RUN leaves the sequence unchanged.
  - `rst` asserted during RUN clears all outputs immediately, without waiting for a clock edge.
